// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - index/device codes, request word layout and FSM states for the SPI arbiter
package spi_pkg;

  localparam logic [2:0] READ_BYTE   = 3'd1;
  localparam logic [2:0] READ_2BYTE  = 3'd2;
  localparam logic [2:0] READ_4BYTE  = 3'd0;
  localparam logic [2:0] WRITE_BYTE  = 3'd5;
  localparam logic [2:0] WRITE_2BYTE = 3'd6;
  localparam logic [2:0] WRITE_4BYTE = 3'd4;
  localparam logic [2:0] START_BST   = 3'd7;
  localparam logic [2:0] END_BST     = 3'd3;

  localparam logic [1:0] DEV_SPI = 2'b01;
  localparam logic [1:0] DEV_MMU = 2'b00;

  localparam int DEST_HI = 63;
  localparam int DEST_LO = 62;
  localparam int ORIG_HI = 61;
  localparam int ORIG_LO = 60;
  localparam int IDX_HI  = 59;
  localparam int IDX_LO  = 57;
  localparam int ADDR_HI = 56;
  localparam int ADDR_LO = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    BURST
  } state_t;

  function automatic logic is_read(input logic [2:0] idx);
    return (idx == READ_BYTE) || (idx == READ_2BYTE) || (idx == READ_4BYTE);
  endfunction

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_rr_arb.sv
// rtl/spi_rr_arb.sv - two-way round-robin grant with a last-winner pointer
module spi_rr_arb
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last;

  always_comb begin
    gnt_id = (req == 2'b11) ? ~last : req[1];
    gnt    = (req == 2'b00) ? 2'b00 : id_onehot(gnt_id);
  end

  // pointer comes out of reset at 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (advance && (req != 2'b00)) begin
      last <= gnt_id;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - arbitrates two requesters onto one SPI master, with burst lock and read timeout
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [1:0]  req_pndgn,
  input  logic [63:0] req_data0,
  input  logic [63:0] req_data1,
  output logic [1:0]  req_pop,
  output logic        spi_pndgn,
  output logic [63:0] spi_dout,
  input  logic        spi_pop,
  input  logic        spi_push,
  input  logic [63:0] spi_din,
  output logic [1:0]  rsp_push,
  output logic [63:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic          lock, lock_next;
  logic          owner, owner_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    req_pop_next, rsp_push_next, rsp_err_next;
  logic          spi_pndgn_next, busy_next;
  logic [63:0]   spi_dout_next, rsp_data_next;
  logic [1:0]    req_avail, gnt;
  logic          gnt_id, take;
  logic [2:0]    cur_idx;

  // while a burst is locked only the owner is visible to the arbiter
  assign req_avail = (state == BURST) ? (req_pndgn & id_onehot(owner)) : req_pndgn;
  assign take      = ((state == IDLE) || (state == BURST)) && (req_avail != 2'b00);
  assign cur_idx   = spi_dout[IDX_HI:IDX_LO];

  spi_rr_arb u_arb (
    .clk     (CLK),
    .rst     (reset),
    .req     (req_avail),
    .advance (take),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    state_next     = state;
    lock_next      = lock;
    owner_next     = owner;
    cnt_next       = cnt;
    req_pop_next   = 2'b00;
    rsp_push_next  = 2'b00;
    rsp_err_next   = 2'b00;
    spi_pndgn_next = spi_pndgn;
    spi_dout_next  = spi_dout;
    rsp_data_next  = rsp_data;
    case (state)
      IDLE, BURST: begin
        if (take) begin
          spi_dout_next                  = gnt_id ? req_data1 : req_data0;
          spi_dout_next[ORIG_HI:ORIG_LO] = {1'b0, gnt_id};
          owner_next                     = gnt_id;
          req_pop_next                   = gnt;
          spi_pndgn_next                 = 1'b1;
          state_next                     = ISSUE;
          if (spi_dout_next[IDX_HI:IDX_LO] == START_BST) begin
            lock_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (spi_pop) begin
          spi_pndgn_next = 1'b0;
          if (is_read(cur_idx)) begin
            cnt_next   = '0;
            state_next = WAIT_RSP;
          end else if (cur_idx == END_BST) begin
            lock_next  = 1'b0;
            state_next = IDLE;
          end else begin
            state_next = lock ? BURST : IDLE;
          end
        end
      end
      WAIT_RSP: begin
        // a response arriving on the timeout edge still counts as a response
        if (spi_push) begin
          rsp_push_next = id_onehot(owner);
          rsp_data_next = spi_din;
          state_next    = lock ? BURST : IDLE;
        end else if (cnt == CNT_LAST) begin
          rsp_err_next  = id_onehot(owner);
          rsp_data_next = '0;
          lock_next     = 1'b0;
          state_next    = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lock      <= 1'b0;
      owner     <= 1'b0;
      cnt       <= '0;
      req_pop   <= 2'b00;
      rsp_push  <= 2'b00;
      rsp_err   <= 2'b00;
      spi_pndgn <= 1'b0;
      spi_dout  <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      lock      <= lock_next;
      owner     <= owner_next;
      cnt       <= cnt_next;
      req_pop   <= req_pop_next;
      rsp_push  <= rsp_push_next;
      rsp_err   <= rsp_err_next;
      spi_pndgn <= spi_pndgn_next;
      spi_dout  <= spi_dout_next;
      rsp_data  <= rsp_data_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - randomized self-checking bench for spi_arbiter against a transaction-level model
module tb_spi_arbiter;

  localparam int TO = 16;
  localparam logic [2:0] I_RD4   = 3'd0;
  localparam logic [2:0] I_RD1   = 3'd1;
  localparam logic [2:0] I_RD2   = 3'd2;
  localparam logic [2:0] I_END   = 3'd3;
  localparam logic [2:0] I_WR1   = 3'd5;
  localparam logic [2:0] I_START = 3'd7;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_pndgn = 2'b00;
  logic [63:0] req_data0 = '0;
  logic [63:0] req_data1 = '0;
  logic [1:0]  req_pop;
  logic        spi_pndgn;
  logic [63:0] spi_dout;
  logic        spi_pop = 1'b0;
  logic        spi_push = 1'b0;
  logic [63:0] spi_din = '0;
  logic [1:0]  rsp_push;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;

  spi_arbiter #(.TIMEOUT(TO)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .req_pndgn (req_pndgn),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_pop   (req_pop),
    .spi_pndgn (spi_pndgn),
    .spi_dout  (spi_dout),
    .spi_pop   (spi_pop),
    .spi_push  (spi_push),
    .spi_din   (spi_din),
    .rsp_push  (rsp_push),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: who was granted last, burst lock/owner, pending words
  logic        m_last  = 1'b1;
  logic        m_lock  = 1'b0;
  logic        m_owner = 1'b0;
  logic [1:0]  m_pend  = 2'b00;
  logic [63:0] m_word [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic logic [1:0] oh(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  function automatic logic is_rd(input logic [2:0] idx);
    return idx <= 3'd2;
  endfunction

  task automatic drive_reqs();
    req_pndgn = m_pend;
    req_data0 = m_word[0];
    req_data1 = m_word[1];
  endtask

  task automatic post(input logic id, input logic [2:0] idx);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[59:57] = idx;
    m_word[id] = w;
    m_pend[id] = 1'b1;
    drive_reqs();
  endtask

  function automatic logic [2:0] pick_idx();
    if (m_lock && ($urandom_range(0, 2) == 0)) return I_END;
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic int pick_push();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return TO;
    return $urandom_range(1, TO - 1);
  endfunction

  // one full transaction: grant on the next edge, pop after pop_dly cycles,
  // then for reads a response at wait edge push_at (0 = never, so timeout)
  task automatic run_txn(input int pop_dly, input int push_at, input logic [63:0] din);
    logic        g;
    logic [2:0]  idx;
    logic [63:0] exp_w;
    bit          done;
    if (m_lock) g = m_owner;
    else if (m_pend == 2'b11) g = ~m_last;
    else g = m_pend[1];
    m_last = g;
    exp_w = m_word[g];
    idx = exp_w[59:57];
    exp_w[61:60] = {1'b0, g};
    if (idx == I_START) begin
      m_lock  = 1'b1;
      m_owner = g;
    end
    tick();
    chk("grant_pop", req_pop, oh(g));
    chk("grant_pndgn", spi_pndgn, 1);
    chk("grant_dout", spi_dout, exp_w);
    chk("grant_busy", busy, 1);
    m_pend[g] = 1'b0;
    drive_reqs();
    for (int i = 0; i < pop_dly; i++) begin
      spi_push = 1'($urandom_range(0, 1));
      spi_din  = {$urandom, $urandom};
      tick();
      chk("hold_pndgn", spi_pndgn, 1);
      chk("hold_dout", spi_dout, exp_w);
      chk("hold_no_pop", req_pop, 0);
      chk("hold_push_ignored", rsp_push, 0);
    end
    spi_push = 1'b0;
    spi_pop  = 1'b1;
    tick();
    spi_pop = 1'b0;
    chk("pop_drop", spi_pndgn, 0);
    chk("pop_no_req_pop", req_pop, 0);
    chk("pop_no_rsp", rsp_push, 0);
    if (!is_rd(idx)) begin
      if (idx == I_END) m_lock = 1'b0;
      chk("wr_busy", busy, m_lock);
    end else begin
      chk("rd_busy", busy, 1);
      done = 0;
      for (int j = 1; j <= TO && !done; j++) begin
        spi_push = (j == push_at);
        spi_din  = (j == push_at) ? din : {$urandom, $urandom};
        tick();
        spi_push = 1'b0;
        if (j == push_at) begin
          chk("rsp_push", rsp_push, oh(g));
          chk("rsp_data", rsp_data, din);
          chk("rsp_no_err", rsp_err, 0);
          chk("rsp_busy", busy, m_lock);
          done = 1;
        end else if (j == TO) begin
          m_lock = 1'b0;
          chk("to_err", rsp_err, oh(g));
          chk("to_data", rsp_data, 0);
          chk("to_no_push", rsp_push, 0);
          chk("to_busy", busy, 0);
          done = 1;
        end else begin
          chk("wait_no_err", rsp_err, 0);
          chk("wait_no_push", rsp_push, 0);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_word[0] = '0;
    m_word[1] = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_pndgn", spi_pndgn, 0);
    chk("rst_req_pop", req_pop, 0);
    chk("rst_rsp_push", rsp_push, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", spi_dout, 0);
    chk("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;
    tick();

    // tie after reset: 0 then 1
    post(0, I_WR1);
    post(1, I_WR1);
    run_txn(0, 0, '0);
    run_txn(1, 0, '0);

    // requester 1 read, pop 3 cycles later, response AAAAAAAA
    post(1, I_RD4);
    m_word[1][56:32] = 25'h555555;
    drive_reqs();
    run_txn(3, 2, 64'hAAAAAAAA);

    // burst by requester 0 holds requester 1 off until END_BST pops
    post(0, I_START);
    post(1, I_WR1);
    run_txn(1, 0, '0);
    post(0, I_WR1);
    run_txn(2, 0, '0);
    post(0, I_RD1);
    run_txn(0, 4, {$urandom, $urandom});
    post(0, I_END);
    run_txn(1, 0, '0);
    run_txn(0, 0, '0);

    // read timeout, then idle
    post(0, I_RD2);
    run_txn(1, 0, '0);
    tick();
    chk("to_next_busy", busy, 0);
    chk("to_pulse_once", rsp_err, 0);

    // timeout inside a burst clears the lock
    post(1, I_START);
    run_txn(0, 0, '0);
    post(1, I_RD1);
    run_txn(2, 0, '0);
    post(0, I_WR1);
    post(1, I_WR1);
    run_txn(0, 0, '0);
    run_txn(0, 0, '0);

    // response on the timeout edge wins
    post(1, I_RD2);
    run_txn(0, TO, {$urandom, $urandom});

    // reset in ISSUE after requester 0 was last granted
    post(0, I_WR1);
    tick();
    chk("r_issue_pop", req_pop, 2'b01);
    chk("r_issue_pndgn", spi_pndgn, 1);
    m_pend = 2'b00;
    drive_reqs();
    #2 reset = 1'b1;
    #1;
    chk("r_async_pndgn", spi_pndgn, 0);
    chk("r_async_busy", busy, 0);
    chk("r_async_pop", req_pop, 0);
    chk("r_async_dout", spi_dout, 0);
    spi_push = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r_after_pop", req_pop, 0);
      chk("r_after_push", rsp_push, 0);
      chk("r_after_err", rsp_err, 0);
      chk("r_after_pndgn", spi_pndgn, 0);
    end
    spi_push = 1'b0;
    m_last = 1'b1;
    m_lock = 1'b0;
    post(0, I_WR1);
    post(1, I_WR1);
    run_txn(0, 0, '0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      if ((m_pend == 2'b00) && !m_lock && ($urandom_range(0, 3) == 0)) begin
        for (int k = 0; k < 2; k++) begin
          spi_push = 1'b1;
          spi_din  = {$urandom, $urandom};
          tick();
          spi_push = 1'b0;
          chk("gap_no_push", rsp_push, 0);
          chk("gap_idle", busy, 0);
          chk("gap_no_pop", req_pop, 0);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (!m_pend[r] && ($urandom_range(0, 1) == 1)) post(1'(r), pick_idx());
      end
      if (!m_lock && (m_pend == 2'b11) && ($urandom_range(0, 7) == 0)) begin
        m_pend[$urandom_range(0, 1)] = 1'b0;
        drive_reqs();
      end
      if (m_lock && !m_pend[m_owner]) post(m_owner, pick_idx());
      if (m_pend == 2'b00) post(1'($urandom_range(0, 1)), pick_idx());
      run_txn($urandom_range(0, 3), pick_push(), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
- REQ-001: Parameter TIMEOUT, default 1024, meaning: maximum cycles to wait for a read response before flagging an error.
- REQ-002: The block SHALL have one clock and one reset; reset is asynchronous and active-high.
- REQ-003: CLK  input  1  system clock, all state updates on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-high reset.
- REQ-005: req_pndgn  input  2  per-requester word pending; index 0 = MMU, index 1 = secondary requester.
- REQ-006: req_data0, req_data1  input  64  request words: [63:62] destination, [61:60] origin, [59:57] index, [56:32] address, [31:0] data.
- REQ-007: req_pop  output  2  one-cycle pulse, word taken from that requester.
- REQ-008: spi_pndgn  output  1  word pending toward the SPI master.
- REQ-009: spi_dout  output  64  word presented to the SPI master.
- REQ-010: spi_pop  input  1  SPI master consumed spi_dout.
- REQ-011: spi_push  input  1  SPI master has a read response.
- REQ-012: spi_din  input  64  read response word.
- REQ-013: rsp_push  output  2  one-cycle pulse delivering rsp_data to requester 0 or 1.
- REQ-014: rsp_data  output  64  routed response word, or zeros on error.
- REQ-015: rsp_err  output  2  one-cycle timeout pulse to the owning requester.
- REQ-016: busy  output  1  high whenever the state is not IDLE.

Function
- REQ-017: FSM states SHALL be IDLE, ISSUE, WAIT_RSP and BURST. All outputs SHALL be registered.
- REQ-018: In IDLE with any req_pndgn bit high at a rising edge, the block SHALL:
  - grant one requester;
  - latch its word, with [61:60] overwritten by {1'b0, requester id};
  - pulse that req_pop bit in the following cycle;
  - set spi_pndgn = 1 in that same following cycle (one-cycle latency);
  - enter ISSUE.
- REQ-019: Round-robin arbitration: when both requesters are pending, the requester not granted last SHALL win. A single pending requester SHALL always win.
- REQ-020: In ISSUE, spi_pndgn and spi_dout SHALL hold stable until spi_pop is sampled high. spi_pndgn SHALL drop the next cycle.
- REQ-021: On spi_pop, the next state SHALL be chosen as follows:
  - index 1, 2 or 0 (reads) -> WAIT_RSP;
  - otherwise, lock active -> BURST;
  - otherwise -> IDLE.
- REQ-022: Index 7 (START_BST) SHALL set the lock, owned by the granted requester. Index 3 (END_BST) SHALL clear the lock once popped. The lock SHALL also be cleared by timeout.
- REQ-023: In BURST, only the lock owner SHALL be granted, with the same timing as REQ-018. The other requester SHALL stay ungranted, without req_pop.
- REQ-024: In WAIT_RSP, spi_push SHALL produce, the next cycle:
  - rsp_data = spi_din;
  - a rsp_push pulse to the owner;
  - a transition to BURST if locked, else IDLE.
- REQ-025: The WAIT_RSP counter SHALL start at 0 on entry. On reaching TIMEOUT-1 without spi_push, the block SHALL:
  - pulse rsp_err to the owner;
  - drive rsp_data = 0;
  - clear the lock;
  - go to IDLE.
- REQ-026: spi_push outside WAIT_RSP SHALL be ignored; no rsp_push is generated.
- REQ-027: spi_push on the same edge as the timeout SHALL be treated as a response, with no rsp_err.
- REQ-028: A req_pndgn bit deasserted before grant SHALL be dropped silently. Requesters hold req_pndgn until they see req_pop.

Reset
- REQ-029: Reset SHALL force the following immediately, including mid-transaction (no completion pulses afterwards):
  - state IDLE;
  - spi_pndgn, req_pop, rsp_push, rsp_err and busy = 0;
  - spi_dout and rsp_data = 0;
  - lock cleared;
  - timeout counter = 0;
  - round-robin pointer = 1, so requester 0 wins the first tie.

Structure
- REQ-030: Package spi_pkg SHALL hold:
  - index codes (READ_BYTE 1, READ_2BYTE 2, READ_4BYTE 0, WRITE_BYTE 5, WRITE_2BYTE 6, WRITE_4BYTE 4, START_BST 7, END_BST 3);
  - device codes (SPI 2'b01, MMU 2'b00);
  - word field bit positions;
  - the FSM state enum.
- REQ-031: A single sub-module spi_rr_arb SHALL implement the 2-input round-robin grant and pointer update.

Verification
- REQ-032: After reset, req_pndgn = 2'b11 with write words (index 5) -> requester 0 is granted first and gets req_pop[0]; requester 1 is granted next; spi_dout[61:60] reads 0 then 1.
- REQ-033: Requester 1 read (index 0, addr 25'h555555); spi_pop 3 cycles later; spi_push with 64'hAAAAAAAA -> rsp_push = 2'b10 with rsp_data = 64'hAAAAAAAA, then IDLE.
- REQ-034: Requester 0 sends START_BST while requester 1 is pending -> requester 1 gets no req_pop until requester 0's END_BST word is popped.
- REQ-035: Read with no spi_push and TIMEOUT = 16 -> rsp_err pulses on the owner's bit after 16 cycles in WAIT_RSP; busy = 0 the next cycle.
- REQ-036: Reset asserted while in ISSUE -> spi_pndgn = 0 immediately; no req_pop or rsp_push follows; the next tie grants requester 0.
